// File: rtl/reg_file_32x32.sv
// 32x32 register file: one synchronous write port, two registered read ports, R0 hardwired to zero.
// Latency: write visible after the capturing edge; read data valid one edge after read=1.
// Backpressure: none; strobes are accepted every cycle, and outputs hold while read=0.
//
// Ports:
//   clk      - system clock, all state changes on rising edge
//   rst      - asynchronous active-low reset, clears registers and read outputs
//   read     - read strobe, both read ports capture when high
//   write    - write strobe, data_w stored at addr_w when high (addr 0 ignored)
//   addr_r1  - read port 1 index
//   addr_r2  - read port 2 index
//   addr_w   - write index
//   data_w   - write data
//   data_r1  - registered read data, port 1
//   data_r2  - registered read data, port 2
module reg_file_32x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr_r1,
    input  logic [4:0]  addr_r2,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    output logic [31:0] data_r1,
    output logic [31:0] data_r2
);

    // Only R1..R31 hold state; R0 is a constant and has no flops.
    logic [31:0] regs [1:31];
    logic [31:1] load_en;
    logic [31:0] rq [0:31];
    logic [31:0] mux_r1;
    logic [31:0] mux_r2;

    // Write decoder: at most one load enable high; address 0 decodes to nothing.
    always_comb begin
        load_en = '0;
        for (int i = 1; i < 32; i++) begin
            load_en[i] = write && (addr_w == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (load_en[i]) begin
                    regs[i] <= data_w;
                end
            end
        end
    end

    // Full 32-entry view for the read muxes, with entry 0 tied to zero.
    always_comb begin
        rq[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rq[i] = regs[i];
        end
    end

    // 32:1 read muxes; they see pre-edge contents, so a same-edge write is not bypassed.
    always_comb begin
        mux_r1 = rq[addr_r1];
        mux_r2 = rq[addr_r2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r1 <= '0;
            data_r2 <= '0;
        end else if (read) begin
            data_r1 <= mux_r1;
            data_r2 <= mux_r2;
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
module tb_reg_file_32x32;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] data_r1;
    logic [31:0] data_r2;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of register values plus the two expected outputs.
    logic [31:0] mdl [32];
    logic [31:0] exp1;
    logic [31:0] exp2;

    reg_file_32x32 dut (
        .clk     (clk),
        .rst     (rst),
        .read    (read),
        .write   (write),
        .addr_r1 (addr_r1),
        .addr_r2 (addr_r2),
        .addr_w  (addr_w),
        .data_w  (data_w),
        .data_r1 (data_r1),
        .data_r2 (data_r2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        exp1 = '0;
        exp2 = '0;
    endtask

    // Called at a negedge: drive inputs, take one rising edge, update the model,
    // return at the following negedge where outputs are sampled.
    task automatic cyc(input logic rd, input logic wr, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
        read    = rd;
        write   = wr;
        addr_r1 = a1;
        addr_r2 = a2;
        addr_w  = aw;
        data_w  = dw;
        @(posedge clk);
        if (rst) begin
            if (rd) begin
                exp1 = mdl[a1];
                exp2 = mdl[a2];
            end
            if (wr && aw != 5'd0) mdl[aw] = dw;
        end
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag);
        tb_check({tag, "_r1"}, data_r1, exp1);
        tb_check({tag, "_r2"}, data_r2, exp2);
    endtask

    initial begin
        rst = 1'b0;
        read = 1'b0;
        write = 1'b0;
        addr_r1 = '0;
        addr_r2 = '0;
        addr_w = '0;
        data_w = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        tb_check("rst_init_r1", data_r1, 32'h0);
        tb_check("rst_init_r2", data_r2, 32'h0);
        rst = 1'b1;

        // Write/read sweep.
        for (int n = 1; n < 32; n++) cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'(n), 32'hA5A50000 + n);
        for (int n = 0; n < 32; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            a1 = 5'(n);
            a2 = 5'(31 - n);
            cyc(1'b1, 1'b0, a1, a2, 5'd0, 32'h0);
            tb_check("sweep_r1", data_r1, (n == 0) ? 32'h0 : 32'hA5A50000 + n);
            tb_check("sweep_r2", data_r2, (n == 31) ? 32'h0 : 32'hA5A50000 + (31 - n));
        end

        // R0 protection.
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        tb_check("r0_protect", data_r1, 32'h0);

        // Same-edge collision: old value first, new value on a later read.
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h11111111);
        cyc(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 32'h22222222);
        tb_check("collide_old", data_r1, 32'h11111111);
        cyc(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
        tb_check("collide_new", data_r1, 32'h22222222);

        // Hold while read=0 even though the source register changes.
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hDEADBEEF);
        cyc(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        tb_check("hold_cap", data_r1, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0);
            tb_check("hold", data_r1, 32'hDEADBEEF);
        end

        // Dual-port same address.
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'hCAFEF00D);
        cyc(1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);
        tb_check("dual_r1", data_r1, 32'hCAFEF00D);
        tb_check("dual_r2", data_r2, 32'hCAFEF00D);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            chk_outs("rand");
        end

        // Asynchronous reset between edges: outputs must clear with no clock edge.
        for (int n = 1; n < 32; n++) cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'(n), $urandom | 32'h1);
        cyc(1'b1, 1'b0, 5'd3, 5'd17, 5'd0, 32'h0);
        chk_outs("pre_rst");
        #2 rst = 1'b0;
        #1;
        tb_check("async_rst_r1", data_r1, 32'h0);
        tb_check("async_rst_r2", data_r2, 32'h0);
        mdl_reset();
        @(negedge clk);
        // Strobes are ignored while reset is held across an edge.
        cyc(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 32'h12345678);
        chk_outs("rst_ignore");
        rst = 1'b1;
        for (int n = 0; n < 32; n++) begin
            cyc(1'b1, 1'b0, 5'(n), 5'(31 - n), 5'd0, 32'h0);
            tb_check("post_rst_r1", data_r1, 32'h0);
            tb_check("post_rst_r2", data_r2, 32'h0);
        end

        // More random traffic after reset.
        for (int k = 0; k < 200; k++) begin
            cyc(($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0),
                5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            chk_outs("rand2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
